key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Front-end conditioner for the board push-buttons; sits directly upstream of the recorder/player control FSM.
- Synchronises, debounces and edge-detects NUM_KEYS active-low raw keys.
- Emits one-cycle active-high press pulses. These drive the record, play and stop key inputs of the top-level FSM.
- Also provides debounced levels and release pulses for display/LED logic.

Parameters:
- NUM_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz).
- LONG_CYCLES, 12000000, hold time in cycles, measured from the accepted press, for a long-press event (1 s at 12 MHz; used only with the optional feature).
- CNT_W, $clog2(LONG_CYCLES+1), counter width; must cover max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_key_n, input, NUM_KEYS, raw asynchronous keys; 0 = pressed.
- i_mask, input, 1, when 1, suppresses o_press, o_release and o_long pulses; state tracking continues.
- o_press, output, NUM_KEYS, one-cycle pulse per accepted press.
- o_release, output, NUM_KEYS, one-cycle pulse per accepted release.
- o_level, output, NUM_KEYS, debounced level; 1 = held.
- o_long, output, NUM_KEYS, one-cycle long-press pulse (only with KEY_LONG_PRESS_EN; otherwise tied 0).
- One clock, i_clk; reset is asynchronous and active-low, i_rst_n.

Behaviour:
- Reset:
  - Synchronisers load 1 (released).
  - All FSMs go to S_RELEASED; counters clear.
  - o_press, o_release, o_long and o_level are 0.
- Synchroniser: 2-FF per key; synchronised pressed = ~sync[1]. The raw input sampled at edge N is visible to the FSM at edge N+2.
- Per-key FSM, fully independent per channel, with one counter each. States and transitions:
  - S_RELEASED: counter is 0. Pressed sample → S_PRESS_WAIT, counter=1.
  - S_PRESS_WAIT: pressed and counter<DEBOUNCE_CYCLES-1 → counter+1. Pressed and counter==DEBOUNCE_CYCLES-1 → S_PRESSED, counter=0, o_press pulse, o_level=1. Released sample → S_RELEASED, counter=0; this is bounce and produces no pulse.
  - S_PRESSED: released sample → S_RELEASE_WAIT, counter=1. Otherwise the counter increments and saturates at LONG_CYCLES.
  - S_RELEASE_WAIT: mirror of S_PRESS_WAIT. Released for DEBOUNCE_CYCLES consecutive samples → S_RELEASED, o_release pulse, o_level=0. Pressed sample → back to S_PRESSED; the long-press counter is restored to LONG_CYCLES if it was already saturated, otherwise it is cleared.
- Latency: a clean press first sampled at edge N gives o_press high in the cycle after edge N+1+DEBOUNCE_CYCLES. That is exactly DEBOUNCE_CYCLES+2 cycles from the raw change to the pulse.
- Pulses are registered and high for exactly one cycle.
  - At most one o_press per accepted press, regardless of hold length.
  - o_press and o_release never assert in the same cycle for one key.
- Simultaneous keys: each channel asserts its own pulse; multiple o_press bits may be high together. No priority is applied here; the consuming FSM resolves it.
- i_mask:
  - Gates pulse outputs combinationally at the register input, i.e. the masked event is lost, not deferred.
  - o_level is never masked.
- Mid-operation reset: returns everything to the reset state immediately. No pulse is generated on reset release, even if the key is held; the press must first be debounced.
- DEBOUNCE_CYCLES must be ≥2 (elaboration assertion).

Optional Feature:
- KEY_LONG_PRESS_EN defined:
  - In S_PRESSED, when the counter reaches LONG_CYCLES, o_long pulses once for one cycle. The counter then saturates, so there is no repeat until release is accepted.
  - The top level uses this for long-hold stop/reset.
- Undefined: o_long is constant 0, the long-press counter logic is removed, and the counter width only needs to cover DEBOUNCE_CYCLES.

Test Plan:
- Params DEBOUNCE_CYCLES=4, LONG_CYCLES=16. Reset, i_key_n=3'b111 → all outputs 0 for 20 cycles.
- Key0 driven low at edge 10 and held → o_press[0] high only in the cycle after edge 15; o_level[0]=1 from then; o_press[1:2] stay 0.
- Key1 toggles low 3 cycles / high 1 cycle, repeated 5 times → no o_press[1]. After a final stable low, o_press[1] fires after 6 cycles.
- Keys 0 and 2 dropped in the same cycle → o_press=3'b101 in a single cycle. On simultaneous release, o_release=3'b101 after 4+2 cycles.
- Key0 held with i_mask=1 → no o_press, o_level[0]=1. Release with i_mask=0 → o_release[0] pulses once.
- KEY_LONG_PRESS_EN: hold key2 for 30 cycles after acceptance → exactly one o_long[2], 16 cycles after o_press[2]. Assert i_rst_n=0 while held → all outputs 0 next cycle, no o_press on reset release until 6 cycles later.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: 2-FF synchroniser, per-key debounce FSM and press/release pulses for active-low keys.
// Long-press pulse detection is compiled in only when KEY_LONG_PRESS_EN is defined.
`default_nettype none

module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  input  logic                i_mask,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_long
);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (CNT_W < $clog2(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("key_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
`ifdef KEY_LONG_PRESS_EN
  if (CNT_W < $clog2(LONG_CYCLES + 1)) begin : g_bad_long_w
    $error("key_conditioner: CNT_W too narrow for LONG_CYCLES");
  end
`endif

  // Synchronisers idle at 1 so a reset looks like "all keys released".
  logic [NUM_KEYS-1:0] sync0_q;
  logic [NUM_KEYS-1:0] sync1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync0_q <= '1;
      sync1_q <= '1;
    end else begin
      sync0_q <= i_key_n;
      sync1_q <= sync0_q;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             release_q;
    logic             level_q;
    logic             key_pressed;
`ifdef KEY_LONG_PRESS_EN
    logic             long_q;
    logic             sat_q;
`endif

    assign key_pressed = ~sync1_q[k];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q   <= S_RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        level_q   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_q    <= 1'b0;
        sat_q     <= 1'b0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_q    <= 1'b0;
`endif
        case (state_q)
          S_RELEASED: begin
            if (key_pressed) begin
              state_q <= S_PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          S_PRESS_WAIT: begin
            if (!key_pressed) begin
              state_q <= S_RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == DB_LAST) begin
              state_q <= S_PRESSED;
              cnt_q   <= '0;
              press_q <= ~i_mask;
              level_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          S_PRESSED: begin
            if (!key_pressed) begin
              state_q <= S_RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
`ifdef KEY_LONG_PRESS_EN
              // Remember saturation so a bounce back to PRESSED cannot re-fire o_long.
              sat_q   <= (cnt_q == LONG_MAX);
            end else if (cnt_q != LONG_MAX) begin
              cnt_q  <= cnt_q + CNT_ONE;
              long_q <= (cnt_q == LONG_LAST) && !i_mask;
`endif
            end
          end
          S_RELEASE_WAIT: begin
            if (key_pressed) begin
              state_q <= S_PRESSED;
`ifdef KEY_LONG_PRESS_EN
              cnt_q   <= sat_q ? LONG_MAX : '0;
`else
              cnt_q   <= '0;
`endif
            end else if (cnt_q == DB_LAST) begin
              state_q   <= S_RELEASED;
              cnt_q     <= '0;
              release_q <= ~i_mask;
              level_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= S_RELEASED;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_level[k]   = level_q;
`ifdef KEY_LONG_PRESS_EN
    assign o_long[k]    = long_q;
`endif
  end

`ifndef KEY_LONG_PRESS_EN
  assign o_long = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulse events are queued with their due cycle
// when keys are driven, and every cycle the outputs are compared against the due events.
`default_nettype none

module tb_key_conditioner;

  localparam int NK = 3;
  localparam int DB = 4;
  localparam int LC = 16;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic          mask;
  logic [NK-1:0] o_press;
  logic [NK-1:0] o_release;
  logic [NK-1:0] o_level;
  logic [NK-1:0] o_long;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .CNT_W          ($clog2(LC + 1))
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_key_n  (key_n),
    .i_mask   (mask),
    .o_press  (o_press),
    .o_release(o_release),
    .o_level  (o_level),
    .o_long   (o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
    logic [NK-1:0] set;
    logic [NK-1:0] clr;
  } ev_t;

  ev_t           q[$];
  logic [NK-1:0] exp_level = '0;
  int            n_checks  = 0;
  int            n_pass    = 0;
  bit            mon_en    = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  task automatic push(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r,
                      input logic [NK-1:0] l, input logic [NK-1:0] s, input logic [NK-1:0] cl);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.set = s; e.clr = cl;
    q.push_back(e);
  endtask

  // Returns the posedge number at which the new key value is first sampled.
  task automatic drive(input logic [NK-1:0] kn, input logic m, output int n);
    @(negedge clk);
    key_n = kn;
    mask  = m;
    n     = cyc + 1;
  endtask

  task automatic wait_cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Per-cycle monitor: pops every event due this cycle and compares all outputs.
  always @(negedge clk) begin
    logic [NK-1:0] ep, er, el, es, ec;
    if (mon_en) begin
      ep = '0; er = '0; el = '0; es = '0; ec = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          ep |= q[i].press; er |= q[i].rel; el |= q[i].lng;
          es |= q[i].set;   ec |= q[i].clr;
          q.delete(i);
        end
      end
      if (!rst_n) exp_level = '0;
      else        exp_level = (exp_level | es) & ~ec;
      check("press",   32'(o_press),   32'(ep));
      check("release", 32'(o_release), 32'(er));
      check("long",    32'(o_long),    32'(el));
      check("level",   32'(o_level),   32'(exp_level));
    end
  end

  initial begin
    int n, r, p;
    rst_n = 1'b0;
    key_n = '1;
    mask  = 1'b0;
    wait_cyc(3);
    mon_en = 1'b1;
    wait_cyc(2);
    @(negedge clk); #1 rst_n = 1'b1;
    wait_cyc(20);

    // Clean press on key0, held.
    drive(3'b110, 1'b0, n);
    push(n + DB + 1, 3'b001, '0, '0, 3'b001, '0);
    wait_cyc(10);

    // Key1 bounces: 3 pressed samples then 1 released, five times; then settles low.
    for (int i = 0; i < 5; i++) begin
      drive(3'b100, 1'b0, n);
      wait_cyc(2);
      drive(3'b110, 1'b0, n);
    end
    drive(3'b100, 1'b0, n);
    push(n + DB + 1, 3'b010, '0, '0, 3'b010, '0);
    wait_cyc(10);
    drive(3'b111, 1'b0, r);
    push(r + DB + 1, '0, 3'b011, '0, '0, 3'b011);
    wait_cyc(10);

    // Keys 0 and 2 together, short hold, released together.
    drive(3'b010, 1'b0, n);
    push(n + DB + 1, 3'b101, '0, '0, 3'b101, '0);
    wait_cyc(8);
    drive(3'b111, 1'b0, r);
    push(r + DB + 1, '0, 3'b101, '0, '0, 3'b101);
    wait_cyc(10);

    // Masked press on key0: level follows, pulse lost; unmasked release pulses.
    drive(3'b110, 1'b1, n);
    push(n + DB + 1, '0, '0, '0, 3'b001, '0);
    wait_cyc(10);
    drive(3'b111, 1'b0, r);
    push(r + DB + 1, '0, 3'b001, '0, '0, 3'b001);
    wait_cyc(10);

    // Long hold on key2, a one-sample release glitch after saturation, then release.
    drive(3'b011, 1'b0, n);
    p = n + DB + 1;
    push(p, 3'b100, '0, '0, 3'b100, '0);
`ifdef KEY_LONG_PRESS_EN
    push(p + LC, '0, '0, 3'b100, '0, '0);
`endif
    wait_cyc(35);
    drive(3'b111, 1'b0, n);
    drive(3'b011, 1'b0, n);
    wait_cyc(20);
    drive(3'b111, 1'b0, r);
    push(r + DB + 1, '0, 3'b100, '0, '0, 3'b100);
    wait_cyc(10);

    // Reset while key2 is held: outputs clear, press must re-debounce after release of reset.
    drive(3'b011, 1'b0, n);
    push(n + DB + 1, 3'b100, '0, '0, 3'b100, '0);
    wait_cyc(10);
    @(negedge clk); #1 rst_n = 1'b0;
    wait_cyc(3);
    @(negedge clk); #1 rst_n = 1'b1;
    n = cyc + 1;
    push(n + DB + 1, 3'b100, '0, '0, 3'b100, '0);
    wait_cyc(12);
    drive(3'b111, 1'b0, r);
    push(r + DB + 1, '0, 3'b100, '0, '0, 3'b100);
    wait_cyc(12);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
